// File: rtl/nios2_c_sd_spi_if.sv
// Avalon-MM slave bus bundle for the SD SPI byte engine.
interface nios2_c_sd_spi_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/nios2_c_sd_spi.sv
// SPI mode-0 byte engine for the SD socket behind an Avalon-MM slave.
// Define NIOS2_C_SD_SPI_IRQ_EN to enable the done interrupt (addr3 bit1 = irq_en).
module nios2_c_sd_spi #(
  parameter int unsigned DEFAULT_DIV = 124,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  nios2_c_sd_spi_if.slave   bus,
  output logic              sd_clk,
  output logic              sd_mosi,
  input  logic              sd_miso,
  output logic              sd_cs_n,
  output logic              irq
);

  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] reload_q, reload_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           txshift_q, txshift_d;
  logic [7:0]           rxshift_q, rxshift_d;
  logic [7:0]           rxdata_q, rxdata_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sd_clk_q, sd_clk_d;
  logic                 sd_mosi_q, sd_mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 irq_en_q, irq_en_d;
  logic                 wr_c;
  logic                 unused_c;

  assign unused_c = ^{bus.read_n, bus.writedata};

  // Register writes, then the bit engine; a done set on completion overrides an addr1 clear.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    txshift_d = txshift_q;
    rxshift_d = rxshift_q;
    rxdata_d  = rxdata_q;
    bitcnt_d  = bitcnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    sd_clk_d  = sd_clk_q;
    sd_mosi_d = sd_mosi_q;
    cs_n_d    = cs_n_q;
    irq_en_d  = irq_en_q;
    wr_c      = bus.chipselect & ~bus.write_n;

    if (wr_c) begin
      case (bus.address)
        2'd1: done_d = 1'b0;
        2'd2: div_d  = DIV_WIDTH'(bus.writedata);
        2'd3: begin
          // Writing 1 to bit0 selects the card (sd_cs_n low).
          cs_n_d = ~bus.writedata[0];
`ifdef NIOS2_C_SD_SPI_IRQ_EN
          irq_en_d = bus.writedata[1];
`endif
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (wr_c && bus.address == 2'd0) begin
          txshift_d = bus.writedata[7:0];
          sd_mosi_d = bus.writedata[7];
          reload_d  = div_q;
          cnt_d     = '0;
          bitcnt_d  = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (cnt_q == reload_q) begin
          cnt_d     = '0;
          sd_clk_d  = 1'b1;
          rxshift_d = {rxshift_q[6:0], sd_miso};
          state_d   = HIGH;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      HIGH: begin
        if (cnt_q == reload_q) begin
          cnt_d    = '0;
          sd_clk_d = 1'b0;
          if (bitcnt_q == BIT_W'(7)) begin
            rxdata_d = rxshift_q;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            txshift_d = {txshift_q[6:0], 1'b1};
            sd_mosi_d = txshift_q[6];
            bitcnt_d  = bitcnt_q + BIT_W'(1);
            state_d   = LOW;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= DIV_WIDTH'(DEFAULT_DIV);
      reload_q  <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q     <= '0;
      txshift_q <= 8'hFF;
      rxshift_q <= 8'h00;
      rxdata_q  <= 8'h00;
      bitcnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sd_clk_q  <= 1'b0;
      sd_mosi_q <= 1'b1;
      cs_n_q    <= 1'b1;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      txshift_q <= txshift_d;
      rxshift_q <= rxshift_d;
      rxdata_q  <= rxdata_d;
      bitcnt_q  <= bitcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sd_clk_q  <= sd_clk_d;
      sd_mosi_q <= sd_mosi_d;
      cs_n_q    <= cs_n_d;
      irq_en_q  <= irq_en_d;
    end
  end

`ifdef NIOS2_C_SD_SPI_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = done_q & irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Zero-wait-state read mux.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = 32'(rxdata_q);
      2'd1: bus.readdata = 32'({done_q, busy_q});
      2'd2: bus.readdata = 32'(div_q);
      2'd3: bus.readdata = 32'({irq_en_q, ~cs_n_q});
      default: bus.readdata = '0;
    endcase
  end

  assign sd_clk  = sd_clk_q;
  assign sd_mosi = sd_mosi_q;
  assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_nios2_c_sd_spi.sv
// Self-checking bench for nios2_c_sd_spi: scoreboard of expected received bytes plus sd_clk/sd_mosi monitors.
module tb_nios2_c_sd_spi;
  localparam int unsigned DEF_DIV = 124;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sd_clk, sd_mosi, sd_miso, sd_cs_n, irq;

  nios2_c_sd_spi_if bus();

  nios2_c_sd_spi #(.DEFAULT_DIV(DEF_DIV), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_miso(sd_miso), .sd_cs_n(sd_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] sb[$];

  // Monitors: cycle counter, sd_clk rises, high-phase widths, sd_mosi stability while sd_clk high.
  int cyc = 0, rises = 0, hi_bad = 0, mosi_bad = 0, hi_run = 0, exp_half = 1;
  logic prev_clk = 1'b0, prev_mosi = 1'b1;
  logic [7:0] mosi_cap = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge sd_clk) begin
    rises    <= rises + 1;
    mosi_cap <= {mosi_cap[6:0], sd_mosi};
  end

  always @(negedge clk) begin
    prev_clk  <= sd_clk;
    prev_mosi <= sd_mosi;
    if (sd_clk === 1'b1 && prev_clk === 1'b1 && sd_mosi !== prev_mosi) mosi_bad <= mosi_bad + 1;
    if (sd_clk === 1'b1) hi_run <= hi_run + 1;
    else if (hi_run != 0) begin
      if (hi_run != exp_half) hi_bad <= hi_bad + 1;
      hi_run <= 0;
    end
  end

  // Card model: loopback or a byte presented MSB first, advancing after each sd_clk rise.
  logic       loop_en = 1'b1;
  logic [7:0] miso_byte = 8'hFF;
  int         miso_base = 0;
  int         miso_idx;
  always_comb begin
    miso_idx = rises - miso_base;
    if (loop_en) sd_miso = sd_mosi;
    else if (miso_idx >= 0 && miso_idx < 8) sd_miso = miso_byte[3'(7 - miso_idx)];
    else sd_miso = 1'b1;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic start_tx(input logic [7:0] tx, input logic [7:0] exp_rx, output int t0);
    bus_write(2'd0, 32'(tx));
    t0 = cyc;
    sb.push_back(exp_rx);
  endtask

  // Returns cycles from the start write to busy low, or -1 if the budget expires.
  task automatic wait_idle(input int t0, input int budget, output int dur);
    dur = -1;
    bus.address = 2'd1; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.readdata[0] === 1'b0) begin
        dur = cyc - t0;
        break;
      end
    end
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1; bus.writedata = '0;
    #2 reset_n = 1'b0;
    #3;
    n_chk++; if (sd_clk !== 1'b0) $display("FAIL reset_sd_clk got=%b want=0", sd_clk); else n_pass++;
    n_chk++; if (sd_mosi !== 1'b1) $display("FAIL reset_sd_mosi got=%b want=1", sd_mosi); else n_pass++;
    n_chk++; if (sd_cs_n !== 1'b1) $display("FAIL reset_sd_cs_n got=%b want=1", sd_cs_n); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b want=0", irq); else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL reset_addr0 got=%h want=0", rd); else n_pass++;
    bus_read(2'd1, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL reset_addr1 got=%h want=0", rd); else n_pass++;
    bus_read(2'd2, rd);
    n_chk++; if (rd !== 32'(DEF_DIV)) $display("FAIL reset_addr2 got=%0d want=%0d", rd, DEF_DIV); else n_pass++;
    bus_read(2'd3, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL reset_addr3 got=%h want=0", rd); else n_pass++;
  endtask

  task automatic test_loopback;
    logic [31:0] rd;
    logic [7:0]  exp;
    int t0, dur, r0, hb;
    bus_write(2'd2, 32'd0);
    exp_half = 1; loop_en = 1'b1;
    r0 = rises; hb = hi_bad;
    start_tx(8'hA5, 8'hA5, t0);
    wait_idle(t0, 100, dur);
    n_chk++; if (dur != 16) $display("FAIL loop_byte_time got=%0d want=16", dur); else n_pass++;
    n_chk++; if (rises - r0 != 8) $display("FAIL loop_pulses got=%0d want=8", rises - r0); else n_pass++;
    n_chk++; if (mosi_cap !== 8'hA5) $display("FAIL loop_mosi got=%h want=a5", mosi_cap); else n_pass++;
    bus_read(2'd1, rd);
    n_chk++; if (rd !== 32'h2) $display("FAIL loop_status got=%h want=2", rd); else n_pass++;
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL loop_rxdata got=%h want=%h", rd, exp); else n_pass++;
    n_chk++; if (hi_bad != hb) $display("FAIL loop_high_width bad_runs=%0d want=0", hi_bad - hb); else n_pass++;
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL done_clear got=%h want=0", rd); else n_pass++;
  endtask

  task automatic test_pattern;
    logic [31:0] rd;
    logic [7:0]  exp;
    int t0, dur, r0, hb, mb;
    bus_write(2'd2, 32'd3);
    exp_half = 4; loop_en = 1'b0; miso_byte = 8'hC3; miso_base = rises;
    r0 = rises; hb = hi_bad; mb = mosi_bad;
    start_tx(8'h3C, 8'hC3, t0);
    wait_idle(t0, 200, dur);
    n_chk++; if (dur != 64) $display("FAIL pat_byte_time got=%0d want=64", dur); else n_pass++;
    n_chk++; if (rises - r0 != 8) $display("FAIL pat_pulses got=%0d want=8", rises - r0); else n_pass++;
    n_chk++; if (mosi_cap !== 8'h3C) $display("FAIL pat_mosi got=%h want=3c", mosi_cap); else n_pass++;
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL pat_rxdata got=%h want=%h", rd, exp); else n_pass++;
    n_chk++; if (hi_bad != hb) $display("FAIL pat_high_width bad_runs=%0d want=0", hi_bad - hb); else n_pass++;
    n_chk++; if (mosi_bad != mb) $display("FAIL pat_mosi_stable changes=%0d want=0", mosi_bad - mb); else n_pass++;
    loop_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic [7:0]  exp;
    int t0, dur, r0;
    bus_write(2'd2, 32'd1);
    exp_half = 2;
    r0 = rises;
    start_tx(8'h55, 8'h55, t0);
    repeat (5) @(negedge clk);
    bus_write(2'd0, 32'h11);
    bus_write(2'd2, 32'd0);
    wait_idle(t0, 200, dur);
    n_chk++; if (dur != 32) $display("FAIL b2b_kept_timing got=%0d want=32", dur); else n_pass++;
    n_chk++; if (mosi_cap !== 8'h55) $display("FAIL b2b_mosi got=%h want=55", mosi_cap); else n_pass++;
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL b2b_rxdata got=%h want=%h", rd, exp); else n_pass++;
    r0 = rises;
    repeat (40) @(negedge clk);
    n_chk++; if (rises != r0) $display("FAIL b2b_no_second got=%0d want=0", rises - r0); else n_pass++;
    bus_read(2'd1, rd);
    n_chk++; if (rd !== 32'h2) $display("FAIL b2b_status got=%h want=2", rd); else n_pass++;
    exp_half = 1;
    start_tx(8'h0F, 8'h0F, t0);
    wait_idle(t0, 200, dur);
    n_chk++; if (dur != 16) $display("FAIL b2b_new_div got=%0d want=16", dur); else n_pass++;
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL b2b_rxdata2 got=%h want=%h", rd, exp); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic [7:0]  exp;
    int t0, dur, r0, hb;
    bit reached;
    bus_write(2'd3, 32'h1);
    n_chk++; if (sd_cs_n !== 1'b0) $display("FAIL cs_select got=%b want=0", sd_cs_n); else n_pass++;
    bus_write(2'd2, 32'd1);
    exp_half = 2;
    r0 = rises;
    bus_write(2'd0, 32'hF0);
    reached = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rises - r0 >= 5) begin reached = 1'b1; break; end
    end
    n_chk++; if (!reached) $display("FAIL mid_reach_bit4 got=%0d rises want=5", rises - r0); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++; if (sd_clk !== 1'b0) $display("FAIL mid_sd_clk got=%b want=0", sd_clk); else n_pass++;
    n_chk++; if (sd_mosi !== 1'b1) $display("FAIL mid_sd_mosi got=%b want=1", sd_mosi); else n_pass++;
    n_chk++; if (sd_cs_n !== 1'b1) $display("FAIL mid_sd_cs_n got=%b want=1", sd_cs_n); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL mid_rxdata got=%h want=0", rd); else n_pass++;
    bus_read(2'd1, rd);
    n_chk++; if (rd !== 32'h0) $display("FAIL mid_status got=%h want=0", rd); else n_pass++;
    bus_read(2'd2, rd);
    n_chk++; if (rd !== 32'(DEF_DIV)) $display("FAIL mid_div got=%0d want=%0d", rd, DEF_DIV); else n_pass++;
    bus_write(2'd2, 32'd0);
    exp_half = 1;
    hb = hi_bad;
    start_tx(8'h96, 8'h96, t0);
    wait_idle(t0, 100, dur);
    n_chk++; if (dur != 16) $display("FAIL mid_next_time got=%0d want=16", dur); else n_pass++;
    n_chk++; if (mosi_cap !== 8'h96) $display("FAIL mid_next_mosi got=%h want=96", mosi_cap); else n_pass++;
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL mid_next_rxdata got=%h want=%h", rd, exp); else n_pass++;
    n_chk++; if (hi_bad != hb) $display("FAIL mid_next_width bad_runs=%0d want=0", hi_bad - hb); else n_pass++;
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    logic [7:0]  exp;
    int t0, dur;
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd);
`ifdef NIOS2_C_SD_SPI_IRQ_EN
    n_chk++; if (rd !== 32'h2) $display("FAIL irq_en_read got=%h want=2", rd); else n_pass++;
`else
    n_chk++; if (rd !== 32'h0) $display("FAIL irq_en_read got=%h want=0", rd); else n_pass++;
`endif
    start_tx(8'h3A, 8'h3A, t0);
    wait_idle(t0, 100, dur);
    n_chk++; if (dur != 16) $display("FAIL irq_byte_time got=%0d want=16", dur); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_at_done got=%b want=0", irq); else n_pass++;
    @(posedge clk); #1;
`ifdef NIOS2_C_SD_SPI_IRQ_EN
    n_chk++; if (irq !== 1'b1) $display("FAIL irq_rise got=%b want=1", irq); else n_pass++;
`else
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_stays_low got=%b want=0", irq); else n_pass++;
`endif
    bus_read(2'd0, rd);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    n_chk++; if (rd !== 32'(exp)) $display("FAIL irq_rxdata got=%h want=%h", rd, exp); else n_pass++;
    bus_write(2'd1, 32'h0);
    @(posedge clk); #1;
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_fall got=%b want=0", irq); else n_pass++;
    n_chk++; if (sb.size() != 0) $display("FAIL sb_leftover got=%0d want=0", sb.size()); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time_limit got=expired want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_pattern();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
